// File: rtl/flit_assembler.sv
// rtl/flit_assembler.sv - NoC flit reassembly into per-packet slots with valid/ready output.
// Optional slot age-out is enabled by defining FLIT_ASSEMBLER_TIMEOUT_EN.
module flit_assembler #(
  parameter int NODE_ID         = 0,
  parameter int NODE_COUNT      = 8,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int SLOTS           = 4,
  parameter int INPUT_WIDTH     = 100,
  parameter int MAX_PAYLOAD     = 64,
  parameter int FLIT_PAYLOAD    = 8,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INPUT_WIDTH-1:0]         flit_in,
  input  logic                           flit_valid,
  output logic [MAX_PAYLOAD-1:0]         packet_out,
  output logic [2:0]                     packet_type,
  output logic [$clog2(NODE_COUNT)-1:0]  src_node,
  output logic [PACKET_ID_WIDTH-1:0]     packet_id,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic                           drop
);

  localparam int NODE_W   = $clog2(NODE_COUNT);
  localparam int IDX_W    = $clog2(MAX_PAYLOAD / FLIT_PAYLOAD);
  localparam int MASK_W   = 1 << IDX_W;
  localparam int SLOT_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int SRC_LSB  = IDX_W;
  localparam int ID_LSB   = SRC_LSB + NODE_W;
  localparam int DATA_LSB = ID_LSB + PACKET_ID_WIDTH;
  localparam int KIND_LSB = DATA_LSB + FLIT_PAYLOAD;
  localparam int DEST_LSB = KIND_LSB + 3;
  localparam int VBIT_POS = DEST_LSB + NODE_W;

  localparam logic [2:0] K_DMEM_REQ_READ     = 3'd0;
  localparam logic [2:0] K_DMEM_REQ_WRITE    = 3'd1;
  localparam logic [2:0] K_DMEM_RESP_DATA    = 3'd2;
  localparam logic [2:0] K_DMEM_RESP_WRITTEN = 3'd3;
  localparam logic [2:0] K_DMEM_RESP_BAD     = 3'd4;
  localparam logic [2:0] K_IMEM_REQ_READ     = 3'd5;
  localparam logic [2:0] K_IMEM_RESP_DATA    = 3'd6;
  localparam logic [2:0] K_IMEM_RESP_BAD     = 3'd7;

  typedef enum logic [1:0] {S_FREE, S_FILLING, S_COMPLETE} slot_state_t;

  function automatic int flits_for(input logic [2:0] k);
    case (k)
      K_DMEM_RESP_WRITTEN, K_DMEM_RESP_BAD, K_IMEM_RESP_BAD:   return 1;
      K_DMEM_REQ_READ, K_IMEM_REQ_READ, K_IMEM_RESP_DATA:      return (32 + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD;
      K_DMEM_REQ_WRITE, K_DMEM_RESP_DATA:                      return (64 + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD;
      default:                                                 return (64 + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD;
    endcase
  endfunction

  function automatic int popcnt(input logic [MASK_W-1:0] m);
    int c;
    c = 0;
    for (int i = 0; i < MASK_W; i++) c += int'(m[i]);
    return c;
  endfunction

  logic [IDX_W-1:0]           f_idx;
  logic [NODE_W-1:0]          f_src;
  logic [PACKET_ID_WIDTH-1:0] f_id;
  logic [FLIT_PAYLOAD-1:0]    f_data;
  logic [2:0]                 f_kind;
  logic [NODE_W-1:0]          f_dest;
  logic                       f_vbit;
  logic                       unused_hi;

  assign f_idx     = flit_in[IDX_W-1:0];
  assign f_src     = flit_in[SRC_LSB +: NODE_W];
  assign f_id      = flit_in[ID_LSB +: PACKET_ID_WIDTH];
  assign f_data    = flit_in[DATA_LSB +: FLIT_PAYLOAD];
  assign f_kind    = flit_in[KIND_LSB +: 3];
  assign f_dest    = flit_in[DEST_LSB +: NODE_W];
  assign f_vbit    = flit_in[VBIT_POS];
  assign unused_hi = ^flit_in[INPUT_WIDTH-1:VBIT_POS+1];

  slot_state_t                state_q   [SLOTS];
  slot_state_t                state_d   [SLOTS];
  logic [NODE_W-1:0]          src_q     [SLOTS];
  logic [NODE_W-1:0]          src_d     [SLOTS];
  logic [PACKET_ID_WIDTH-1:0] id_q      [SLOTS];
  logic [PACKET_ID_WIDTH-1:0] id_d      [SLOTS];
  logic [2:0]                 kind_q    [SLOTS];
  logic [2:0]                 kind_d    [SLOTS];
  logic [MAX_PAYLOAD-1:0]     payload_q [SLOTS];
  logic [MAX_PAYLOAD-1:0]     payload_d [SLOTS];
  logic [MASK_W-1:0]          recv_q    [SLOTS];
  logic [MASK_W-1:0]          recv_d    [SLOTS];

  logic [MAX_PAYLOAD-1:0]     out_payload_q, out_payload_d;
  logic [2:0]                 out_kind_q, out_kind_d;
  logic [NODE_W-1:0]          out_src_q, out_src_d;
  logic [PACKET_ID_WIDTH-1:0] out_id_q, out_id_d;
  logic                       valid_q, valid_d;
  logic                       drop_q, drop_d;

  logic              hit, free_found, cpl_found, dup, accept, flit_drop, wr, load_en, timeout_hit;
  logic [SLOT_W-1:0] hit_idx, free_idx, cpl_idx, tgt;
  logic [MASK_W-1:0] new_mask;
  int                n_exp;

`ifdef FLIT_ASSEMBLER_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [AGE_W-1:0] age_q [SLOTS];
  logic [AGE_W-1:0] age_d [SLOTS];
`else
  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be positive");
  end
`endif

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    id_d          = id_q;
    kind_d        = kind_q;
    payload_d     = payload_q;
    recv_d        = recv_q;
    out_payload_d = out_payload_q;
    out_kind_d    = out_kind_q;
    out_src_d     = out_src_q;
    out_id_d      = out_id_q;
    valid_d       = valid_q;
    hit           = 1'b0;
    hit_idx       = '0;
    free_found    = 1'b0;
    free_idx      = '0;
    cpl_found     = 1'b0;
    cpl_idx       = '0;
    new_mask      = '0;
    timeout_hit   = 1'b0;
`ifdef FLIT_ASSEMBLER_TIMEOUT_EN
    age_d         = age_q;
`endif

    // Descending scan so the lowest-index candidate is the one that sticks.
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (state_q[s] == S_FILLING && src_q[s] == f_src && id_q[s] == f_id) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(s);
      end
      if (state_q[s] == S_FREE) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(s);
      end
      if (state_q[s] == S_COMPLETE) begin
        cpl_found = 1'b1;
        cpl_idx   = SLOT_W'(s);
      end
    end

    n_exp     = flits_for(hit ? kind_q[hit_idx] : f_kind);
    accept    = flit_valid & f_vbit;
    dup       = hit && recv_q[hit_idx][f_idx];
    flit_drop = accept && ((f_dest != NODE_W'(NODE_ID)) || (int'(f_idx) >= n_exp) || dup ||
                           (!hit && !free_found));
    wr        = accept && !flit_drop;
    tgt       = hit ? hit_idx : free_idx;

    if (wr) begin
      if (!hit) begin
        state_d[tgt]   = S_FILLING;
        src_d[tgt]     = f_src;
        id_d[tgt]      = f_id;
        kind_d[tgt]    = f_kind;
        payload_d[tgt] = '0;
        recv_d[tgt]    = '0;
      end
      payload_d[tgt][int'(f_idx)*FLIT_PAYLOAD +: FLIT_PAYLOAD] = f_data;
      new_mask    = recv_d[tgt] | (MASK_W'(1) << f_idx);
      recv_d[tgt] = new_mask;
      if (popcnt(new_mask) == n_exp) state_d[tgt] = S_COMPLETE;
`ifdef FLIT_ASSEMBLER_TIMEOUT_EN
      age_d[tgt] = '0;
`endif
    end

`ifdef FLIT_ASSEMBLER_TIMEOUT_EN
    // A flit landing in a slot on its expiry cycle keeps the slot alive.
    for (int s = 0; s < SLOTS; s++) begin
      if (state_q[s] == S_FILLING && !(wr && tgt == SLOT_W'(s))) begin
        if (age_q[s] >= AGE_W'(TIMEOUT_CYCLES - 1)) begin
          state_d[s]  = S_FREE;
          timeout_hit = 1'b1;
        end else begin
          age_d[s] = age_q[s] + 1'b1;
        end
      end
    end
`endif

    load_en = !valid_q || ready_in;
    if (load_en) begin
      valid_d = cpl_found;
      if (cpl_found) begin
        out_payload_d    = payload_q[cpl_idx];
        out_kind_d       = kind_q[cpl_idx];
        out_src_d        = src_q[cpl_idx];
        out_id_d         = id_q[cpl_idx];
        state_d[cpl_idx] = S_FREE;
      end
    end

    drop_d = flit_drop | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SLOTS; s++) begin
        state_q[s]   <= S_FREE;
        src_q[s]     <= '0;
        id_q[s]      <= '0;
        kind_q[s]    <= '0;
        payload_q[s] <= '0;
        recv_q[s]    <= '0;
`ifdef FLIT_ASSEMBLER_TIMEOUT_EN
        age_q[s]     <= '0;
`endif
      end
      out_payload_q <= '0;
      out_kind_q    <= '0;
      out_src_q     <= '0;
      out_id_q      <= '0;
      valid_q       <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      id_q          <= id_d;
      kind_q        <= kind_d;
      payload_q     <= payload_d;
      recv_q        <= recv_d;
`ifdef FLIT_ASSEMBLER_TIMEOUT_EN
      age_q         <= age_d;
`endif
      out_payload_q <= out_payload_d;
      out_kind_q    <= out_kind_d;
      out_src_q     <= out_src_d;
      out_id_q      <= out_id_d;
      valid_q       <= valid_d;
      drop_q        <= drop_d;
    end
  end

  assign packet_out  = out_payload_q;
  assign packet_type = out_kind_q;
  assign src_node    = out_src_q;
  assign packet_id   = out_id_q;
  assign valid_out   = valid_q;
  assign drop        = drop_q;

endmodule

// File: tb/tb_flit_assembler.sv
// tb/tb_flit_assembler.sv - directed checks for flit_assembler.
module tb_flit_assembler;

  localparam logic [2:0] K_DMEM_REQ_READ     = 3'd0;
  localparam logic [2:0] K_DMEM_RESP_DATA    = 3'd2;
  localparam logic [2:0] K_DMEM_RESP_WRITTEN = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [99:0] flit_in;
  logic        flit_valid;
  logic [63:0] packet_out;
  logic [2:0]  packet_type;
  logic [2:0]  src_node;
  logic [4:0]  packet_id;
  logic        valid_out;
  logic        ready_in;
  logic        drop;

  int n_checks = 0;
  int n_fail   = 0;

  flit_assembler #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid),
    .packet_out(packet_out), .packet_type(packet_type), .src_node(src_node),
    .packet_id(packet_id), .valid_out(valid_out), .ready_in(ready_in), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [99:0] mk(input logic [2:0] kind, input logic [2:0] src,
                                     input logic [4:0] id, input logic [2:0] idx,
                                     input logic [7:0] data, input logic [2:0] dest,
                                     input logic vb);
    logic [99:0] f;
    f        = '0;
    f[99:90] = 10'h2A5;
    f[2:0]   = idx;
    f[5:3]   = src;
    f[10:6]  = id;
    f[18:11] = data;
    f[21:19] = kind;
    f[24:22] = dest;
    f[25]    = vb;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] kind, input logic [2:0] src, input logic [4:0] id,
                      input logic [2:0] idx, input logic [7:0] data, input logic [2:0] dest,
                      input logic vb);
    flit_in    = mk(kind, src, id, idx, data, dest, vb);
    flit_valid = 1'b1;
    tick();
    flit_valid = 1'b0;
    flit_in    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    flit_valid = 1'b0;
    flit_in    = '0;
    ready_in   = 1'b1;
    repeat (3) tick();
    check("rst_valid", valid_out, 0);
    check("rst_payload", packet_out, 0);
    check("rst_type", packet_type, 0);
    check("rst_src", src_node, 0);
    check("rst_id", packet_id, 0);
    check("rst_drop", drop, 0);
    rst = 1'b0;
    tick();

    // Flit with vbit clear is ignored even though its dest would cause a drop.
    send(K_DMEM_REQ_READ, 3'd1, 5'd1, 3'd0, 8'h11, 3'd3, 1'b0);
    check("vbit0_no_drop", drop, 0);

    // Single-flit packet.
    send(K_DMEM_RESP_WRITTEN, 3'd2, 5'd5, 3'd0, 8'h00, 3'd0, 1'b1);
    check("single_latency", valid_out, 0);
    tick();
    check("single_valid", valid_out, 1);
    check("single_src", src_node, 2);
    check("single_id", packet_id, 5);
    check("single_type", packet_type, K_DMEM_RESP_WRITTEN);
    check("single_payload", packet_out, 64'h0);
    tick();
    check("single_consumed", valid_out, 0);

    // Out-of-order 8-flit packet.
    for (int i = 7; i >= 0; i--) send(K_DMEM_RESP_DATA, 3'd1, 5'd3, 3'(i), 8'(i), 3'd0, 1'b1);
    check("ooo_latency", valid_out, 0);
    tick();
    check("ooo_valid", valid_out, 1);
    check("ooo_payload", packet_out, 64'h0706050403020100);
    check("ooo_type", packet_type, K_DMEM_RESP_DATA);
    tick();
    check("ooo_consumed", valid_out, 0);

    // Two interleaved 4-flit reads with the consumer stalled.
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(K_DMEM_REQ_READ, 3'd1, 5'd7, 3'(i), 8'(8'h10 + i), 3'd0, 1'b1);
      send(K_DMEM_REQ_READ, 3'd4, 5'd7, 3'(i), 8'(8'h20 + i), 3'd0, 1'b1);
    end
    check("il_first_valid", valid_out, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("il_hold_src", src_node, 1);
      check("il_hold_payload", packet_out, 64'h13121110);
      check("il_hold_valid", valid_out, 1);
    end
    ready_in = 1'b1;
    tick();
    check("il_second_valid", valid_out, 1);
    check("il_second_src", src_node, 4);
    check("il_second_payload", packet_out, 64'h23222120);
    tick();
    check("il_drained", valid_out, 0);

    // Slot overflow, duplicate and wrong-destination drops.
    for (int p = 0; p < 5; p++) begin
      send(K_DMEM_RESP_DATA, 3'(p), 5'd9, 3'd0, 8'(8'hA0 + p), 3'd0, 1'b1);
      check("ovf_drop", drop, (p == 4) ? 64'd1 : 64'd0);
    end
    tick();
    check("ovf_drop_pulse", drop, 0);
    send(K_DMEM_RESP_DATA, 3'd0, 5'd9, 3'd0, 8'hFF, 3'd0, 1'b1);
    check("dup_drop", drop, 1);
    send(K_DMEM_RESP_DATA, 3'd0, 5'd9, 3'd1, 8'hEE, 3'd3, 1'b1);
    check("dest_drop", drop, 1);
    for (int i = 1; i < 8; i++) begin
      send(K_DMEM_RESP_DATA, 3'd0, 5'd9, 3'(i), 8'(8'hA0 + i), 3'd0, 1'b1);
      check("ovf_fill_no_drop", drop, 0);
    end
    tick();
    check("ovf_valid", valid_out, 1);
    check("ovf_payload", packet_out, 64'hA7A6A5A4A3A2A1A0);
    check("ovf_id", packet_id, 9);
    tick();

    // Reset mid-packet discards the partial.
    for (int i = 0; i < 3; i++) send(K_DMEM_RESP_DATA, 3'd6, 5'd1, 3'(i), 8'(8'h60 + i), 3'd0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 3; i < 8; i++) send(K_DMEM_RESP_DATA, 3'd6, 5'd1, 3'(i), 8'(8'h60 + i), 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_valid", valid_out, 0);
    end
    check("rst_mid_payload", packet_out, 0);
    check("rst_mid_src", src_node, 0);
    check("rst_mid_id", packet_id, 0);
    check("rst_mid_type", packet_type, 0);

`ifdef FLIT_ASSEMBLER_TIMEOUT_EN
    begin
      int seen;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      send(K_DMEM_RESP_DATA, 3'd3, 5'd2, 3'd0, 8'h33, 3'd0, 1'b1);
      seen = 0;
      for (int i = 1; i <= 30; i++) begin
        tick();
        if (drop && seen == 0) seen = i;
      end
      check("timeout_cycle", 64'(seen), 64'd10);
      for (int p = 0; p < 4; p++) begin
        send(K_DMEM_RESP_DATA, 3'(p), 5'd20, 3'd0, 8'(p), 3'd0, 1'b1);
        check("timeout_realloc", drop, 0);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_assembler.md
# flit_assembler

Receive-side counterpart of the NoC packet splitter. Sits between the router's local ejection port and the core's memory-request/response logic. Collects flits tagged with (source node, packet id) into per-packet reassembly slots and rebuilds the full payload once every flit has arrived. Completed packets are presented one at a time on a valid/ready interface.

## Interface
- `NODE_ID`, 0: this node's index; flits with another destination are dropped.
- `NODE_COUNT`, 8: nodes on the NoC; `NODE_W = $clog2(NODE_COUNT)`.
- `PACKET_ID_WIDTH`, 5: packet id width.
- `SLOTS`, 4: concurrent reassembly contexts.
- `INPUT_WIDTH`, 100: flit bus width; bits above the used field are ignored.
- `MAX_PAYLOAD`, 64: reassembled payload bits.
- `FLIT_PAYLOAD`, 8: payload bits per flit; `IDX_W = $clog2(MAX_PAYLOAD/FLIT_PAYLOAD)`.
- `TIMEOUT_CYCLES`, 255: slot age limit; used only with `FLIT_ASSEMBLER_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flit_in` in INPUT_WIDTH: flit. Fields from LSB: `idx[IDX_W]`, `src[NODE_W]`, `id[PACKET_ID_WIDTH]`, `data[FLIT_PAYLOAD]`, `kind[3]` (type_packet_type), `dest[NODE_W]`, `vbit[1]`.
- `flit_valid` in 1: `flit_in` is valid this cycle. A flit is accepted only when both `flit_valid` and `vbit` are 1. There is no back-pressure to the NoC.
- `packet_out` out MAX_PAYLOAD: reassembled payload. Flit k occupies bits [k*FLIT_PAYLOAD +: FLIT_PAYLOAD].
- `packet_type` out 3: kind of the packet on `packet_out`.
- `src_node` out NODE_W: source node of the packet.
- `packet_id` out PACKET_ID_WIDTH: packet id.
- `valid_out` out 1: output packet valid.
- `ready_in` in 1: consumer accepts the packet when `valid_out && ready_in`.
- `drop` out 1: one-cycle pulse when a flit is discarded.

## Operation
- Expected flit count N per kind:
  - DMEM_RESP_WRITTEN, DMEM_RESP_BAD, IMEM_RESP_BAD: 1.
  - DMEM_REQ_READ, IMEM_REQ_READ, IMEM_RESP_DATA: ceil(32/FLIT_PAYLOAD).
  - DMEM_REQ_WRITE, DMEM_RESP_DATA: ceil(64/FLIT_PAYLOAD).
- Each slot holds: busy, complete, src, id, kind, payload[MAX_PAYLOAD], recv mask[2^IDX_W], and (with the macro) an age counter.
- Slot state machine: FREE → FILLING on allocation; FILLING → COMPLETE when the mask has N bits set; COMPLETE → FREE when the slot is moved to the output register.
- An accepted flit is handled as follows:
  - Drop and pulse `drop` if any of these hold: `dest != NODE_ID`; `idx >= N`; `recv[idx]` is already set (duplicate); no matching slot and no free slot.
  - Otherwise match a FILLING slot with equal (src, id). If none matches, allocate the lowest-index FREE slot and latch src/id/kind.
  - Write `data` into payload bits [idx*FLIT_PAYLOAD +: FLIT_PAYLOAD] and set `recv[idx]`.
  - The kind of a matched flit is not re-checked. The kind latched from the first flit governs N.
  - Flits may arrive in any order.
- Output register: loaded when empty, or in the same cycle the current packet is accepted. It takes the lowest-index COMPLETE slot and frees that slot.
- A slot freed in cycle t is not allocatable until t+1. A flit arriving in cycle t that would need that slot is dropped.
- Payload bits beyond N*FLIT_PAYLOAD are output as 0. Slot payload is cleared on allocation.

## Timing
- Reset values: `valid_out`=0, `packet_out`=0, `packet_type`=0, `src_node`=0, `packet_id`=0, `drop`=0. All slots FREE with cleared masks.
- Asserting `rst` mid-packet discards every partial and complete packet.
- Latency: the final flit is sampled at edge E and the slot becomes COMPLETE at E. The output is loaded at E+1, and `valid_out`=1 from E+1 onward.
- While `valid_out && !ready_in`, all outputs hold stable.
- Back-to-back throughput is 1 packet/cycle when multiple slots are COMPLETE.
- `drop` is registered and asserts the cycle after the offending flit.
- Accepting one flit per cycle is sustained indefinitely. Output stall only blocks the freeing of COMPLETE slots.

## Configuration
- `FLIT_ASSEMBLER_TIMEOUT_EN` defined:
  - A FILLING slot's age counter resets on allocation and on every flit accepted into it.
  - Otherwise it increments each cycle.
  - When it reaches `TIMEOUT_CYCLES` the slot returns to FREE and `drop` pulses once.
- Undefined: no age counters. A FILLING slot persists until completed or reset.

## Test plan
- Single-flit packet: DMEM_RESP_WRITTEN, src 2, id 5, idx 0 at cycle 0 → `valid_out`=1 at cycle 2 with src 2, id 5, payload 0.
- Out-of-order flits: DMEM_RESP_DATA, src 1, id 3, flits idx 7..0 carrying bytes 0x07..0x00 → `packet_out`=0x0706050403020100.
- Interleaving: two 4-flit reads from src 1 and src 4 alternating flits → two packets out, each with its correct payload; with `ready_in`=0 both held, the first output stable until `ready_in`=1.
- Overflow: 5 distinct partial packets with SLOTS=4 → fifth packet's flit pulses `drop`; duplicate idx and `dest`=3 flits also pulse `drop` and change no data.
- Reset: `rst` asserted after 3 of 8 flits, then the remaining 5 sent → no `valid_out`; all outputs 0.
- Timeout (macro on, TIMEOUT_CYCLES=10): 1 flit of an 8-flit packet then idle → slot freed and `drop` pulse within the timeout expiry cycle; 4 new packets then accepted.
